uart_tx: RTL

//  Serial UART transmitter, 8N1 framing, LSB first, for the transmit direction of the UART link.

---
 rtl/uart_tx.sv | 79 +++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 LSB-first UART transmitter gated by txclken; even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int CLKS_PER_BIT = 1085
) (
  input  logic       txclk,
  input  logic       rst,
  input  logic       txclken,
  input  logic       wr_en,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] bitpos_q, bitpos_d;
  logic [7:0] shreg_q, shreg_d;
  logic tx_q, tx_d, done_q, done_d, last;
  assign last = cnt_q == LAST;
  always_comb begin
    state_d = state_q;
    cnt_d = last ? 16'd0 : cnt_q + 16'd1;
    bitpos_d = bitpos_q;
    shreg_d = shreg_q;
    done_d = 1'b0;
    if (!txclken || state_q == IDLE) begin
      state_d = IDLE;
      cnt_d = 16'd0;
      bitpos_d = 3'd0;
      if (txclken && wr_en) begin
        shreg_d = din;
        state_d = START;
      end
    end else if (last) begin
      case (state_q)
        START: state_d = DATA;
        DATA: begin
          bitpos_d = bitpos_q + 3'd1;
`ifdef UART_TX_PARITY_EN
          state_d = (bitpos_q == 3'd7) ? PARITY : DATA;
`else
          state_d = (bitpos_q == 3'd7) ? STOP : DATA;
`endif
        end
        PARITY: state_d = STOP;
        default: begin
          state_d = IDLE;
          done_d = 1'b1;
        end
      endcase
    end
    // tx is registered from the next state so it changes on the same edge as the FSM
    tx_d = (state_d == START) ? 1'b0 :
           (state_d == DATA) ? shreg_d[bitpos_d] :
           (state_d == PARITY) ? ^shreg_d : 1'b1;
  end
  always_ff @(posedge txclk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= 16'd0;
      bitpos_q <= 3'd0;
      shreg_q <= 8'd0;
      tx_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bitpos_q <= bitpos_d;
      shreg_q <= shreg_d;
      tx_q <= tx_d;
      done_q <= done_d;
    end
  end
  assign tx = tx_q;
  assign tx_done = done_q;
  assign tx_busy = state_q != IDLE;
endmodule
